// File: rtl/serial_read_buffer.sv
// Serial-to-parallel receive stage: start-bit detect, MSB-first shift-in of WIDTH bits,
// and a one-entry valid/ready holding register with a sticky overflow flag.
module serial_read_buffer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             din,
    input  logic             ready,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic             complete_s;
    logic             consumed_s;
    logic             ovf_set_s;
    logic [WIDTH-1:0] word_s;

    // Receive FSM: start detection, shifting and frame completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        complete_s = 1'b0;
        word_s     = {shift_q, din};
        case (state_q)
            IDLE: begin
                if (din) begin
                    state_d = RECEIVE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RECEIVE: begin
                shift_d = word_s[WIDTH-2:0];
                if (cnt_q == LAST_IDX) begin
                    // Returning to IDLE here lets a start bit on the very next edge be taken.
                    complete_s = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = {CW{1'b0}};
                end else begin
                    state_d = RECEIVE;
                    cnt_d   = cnt_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        busy_d = (state_d == RECEIVE);
    end

    // Holding register handshake and overflow bookkeeping.
    always_comb begin
        dout_d     = dout_q;
        valid_d    = valid_q;
        ovf_set_s  = 1'b0;
        consumed_s = valid_q & ready;
        if (complete_s && (!valid_q || consumed_s)) begin
            dout_d  = word_s;
            valid_d = 1'b1;
        end else if (complete_s) begin
            ovf_set_s = 1'b1;
        end else if (consumed_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A drop on the same edge as a clear must leave the flag set.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            shift_q <= {(WIDTH-1){1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_read_buffer.sv
// Directed bench for serial_read_buffer: scoreboard of expected words popped on each
// handshake, plus direct checks of flags and the holding register.
module tb_serial_read_buffer;

    localparam int W = 3;

    logic         clk;
    logic         rstN;
    logic         din;
    logic         ready;
    logic         clr_ovf;
    logic [W-1:0] dout;
    logic         valid;
    logic         busy;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    serial_read_buffer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .din      (din),
        .ready    (ready),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; a handshake seen just before the edge pops the scoreboard.
    task automatic tick();
        logic         hs;
        logic [W-1:0] d;
        hs = valid && ready;
        d  = dout;
        @(posedge clk);
        #1;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("sb_word", 32'(d), 32'(sb.pop_front()));
            end
        end
    endtask

    task automatic send_frame(input logic [W-1:0] word);
        din = 1'b1;
        tick();
        for (int i = W - 1; i >= 0; i--) begin
            din = word[i];
            tick();
        end
        din = 1'b0;
    endtask

    initial begin
        rstN    = 1'b1;
        din     = 1'b0;
        ready   = 1'b0;
        clr_ovf = 1'b0;
        #2 rstN = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #3 rstN = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic frame 1,1,0,1 with ready low
        din = 1'b1; tick();
        chk("t1_busy_start", 32'(busy), 32'd1);
        din = 1'b1; tick();
        din = 1'b0; tick();
        chk("t1_busy_mid", 32'(busy), 32'd1);
        chk("t1_valid_mid", 32'(valid), 32'd0);
        din = 1'b1; sb.push_back(3'b101); tick();
        din = 1'b0;
        chk("t1_dout", 32'(dout), 32'(3'b101));
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("t1_valid_drained", 32'(valid), 32'd0);
        chk("t1_dout_hold", 32'(dout), 32'(3'b101));

        // 2: back-to-back frames with ready held high
        ready = 1'b1;
        sb.push_back(3'b010);
        send_frame(3'b010);
        chk("t2_dout_a", 32'(dout), 32'(3'b010));
        chk("t2_valid_a", 32'(valid), 32'd1);
        sb.push_back(3'b111);
        send_frame(3'b111);
        chk("t2_dout_b", 32'(dout), 32'(3'b111));
        chk("t2_valid_b", 32'(valid), 32'd1);
        chk("t2_ovf", 32'(overflow), 32'd0);
        tick();
        ready = 1'b0;
        chk("t2_valid_drained", 32'(valid), 32'd0);

        // 3: overflow with ready low, then clear, then drain
        sb.push_back(3'b101);
        send_frame(3'b101);
        send_frame(3'b011);
        chk("t3_dout", 32'(dout), 32'(3'b101));
        chk("t3_valid", 32'(valid), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        chk("t3_valid_kept", 32'(valid), 32'd1);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("t3_valid_drained", 32'(valid), 32'd0);

        // 4: completion edge coincides with a consuming handshake
        sb.push_back(3'b001);
        send_frame(3'b001);
        chk("t4_dout_a", 32'(dout), 32'(3'b001));
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b0; ready = 1'b1; sb.push_back(3'b110); tick();
        chk("t4_dout_b", 32'(dout), 32'(3'b110));
        chk("t4_valid", 32'(valid), 32'd1);
        chk("t4_ovf", 32'(overflow), 32'd0);
        tick(); ready = 1'b0;
        chk("t4_valid_drained", 32'(valid), 32'd0);

        // set beats clear on the same edge
        sb.push_back(3'b100);
        send_frame(3'b100);
        din = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1; tick();
        din = 1'b0; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_dout_kept", 32'(dout), 32'(3'b100));
        clr_ovf = 1'b1; ready = 1'b1; tick(); clr_ovf = 1'b0; ready = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // 5: asynchronous reset mid-frame, then a clean frame
        sb.push_back(3'b011);
        send_frame(3'b011);
        din = 1'b1; tick();
        din = 1'b1; tick();
        din = 1'b0; tick();
        #2 rstN = 1'b0;
        #1;
        chk("t5_rst_dout", 32'(dout), 32'd0);
        chk("t5_rst_valid", 32'(valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        rstN = 1'b1;
        din  = 1'b0;
        tick();
        sb.push_back(3'b110);
        send_frame(3'b110);
        chk("t5_dout", 32'(dout), 32'(3'b110));
        chk("t5_valid", 32'(valid), 32'd1);
        ready = 1'b1; tick(); ready = 1'b0;

        // 6: idle line keeps the FSM idle
        din = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_valid", 32'(valid), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
